// File: rtl/archel_pkg.sv
// Shared encodings for the archel pipeline controller: FSM states and
// EX operand forwarding selects.
package archel_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RAW = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding for one source register: picks MEM, then WB, then the
// raw IDEX value, and muxes the data accordingly.
module fwd_unit
   import archel_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RA_W    = 3,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic [RA_W-1:0]   src_i,
   input  logic [RA_W-1:0]   mem_rd_i,
   input  logic              mem_regwrite_i,
   input  logic              mem_memread_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [RA_W-1:0]   wb_rd_i,
   input  logic              wb_regwrite_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic [DATA_W-1:0] raw_i,
   output logic [1:0]        sel_o,
   output logic [DATA_W-1:0] data_o
);

   logic src_ok;
   logic mem_hit;
   logic wb_hit;

   // A load in MEM has no data yet, so only ALU results forward from there.
   assign src_ok  = !(R0_ZERO && (src_i == '0));
   assign mem_hit = src_ok && mem_regwrite_i && !mem_memread_i && (mem_rd_i == src_i);
   assign wb_hit  = src_ok && wb_regwrite_i && (wb_rd_i == src_i);

   always_comb begin
      sel_o  = FWD_RAW;
      data_o = raw_i;
      if (mem_hit) begin
         sel_o  = FWD_MEM;
         data_o = mem_data_i;
      end else if (wb_hit) begin
         sel_o  = FWD_WB;
         data_o = wb_data_i;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Central controller for the archel 5-stage pipeline: run/halt/step FSM,
// load-use stall, forwarding, WB->ID bypass, valid bits and retire counting.
// Define PIPE_PERF_CNT_EN to build the stall/halt performance counters.
module pipe_hazard_ctl
   import archel_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RA_W    = 3,
   parameter int unsigned CNT_W   = 32,
   parameter bit          R0_ZERO = 1'b1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              pause,
   input  logic              step,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rd1_raw,
   input  logic [DATA_W-1:0] id_rd2_raw,
   input  logic [RA_W-1:0]   ex_rs,
   input  logic [RA_W-1:0]   ex_rt,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic              ex_memread,
   input  logic              ex_regwrite,
   input  logic [RA_W-1:0]   mem_rd,
   input  logic              mem_regwrite,
   input  logic              mem_memread,
   input  logic [DATA_W-1:0] mem_fwd_data,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic              wb_regwrite,
   input  logic [DATA_W-1:0] wb_fwd_data,
   input  logic [DATA_W-1:0] ex_opa_raw,
   input  logic [DATA_W-1:0] ex_opb_raw,
   output logic              adv,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              idex_bubble,
   output logic [DATA_W-1:0] id_rd1,
   output logic [DATA_W-1:0] id_rd2,
   output logic [DATA_W-1:0] ex_opa,
   output logic [DATA_W-1:0] ex_opb,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  halt_cnt
);

   state_e           state_q, state_d;
   logic             v_ifid_q, v_ifid_d;
   logic             v_idex_q, v_idex_d;
   logic             v_exmem_q, v_exmem_d;
   logic             v_memwb_q, v_memwb_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic             hz;
   logic             rs_hit, rt_hit;
   logic             wb_id_rs_hit, wb_id_rt_hit;

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_HALT;
      else     state_q <= state_d;
   end

   // FSM next state; step only matters while halted
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HALT: begin
            if (!pause)     state_d = ST_RUN;
            else if (step)  state_d = ST_STEP;
         end
         ST_RUN:  if (pause) state_d = ST_HALT;
         ST_STEP: state_d = pause ? ST_HALT : ST_RUN;
         default: state_d = ST_HALT;
      endcase
   end

   // FSM outputs: advance enables and stall/bubble
   always_comb begin
      adv         = 1'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b0;
      if ((state_q == ST_RUN) || (state_q == ST_STEP)) begin
         adv         = 1'b1;
         pc_we       = ~hz;
         ifid_we     = ~hz;
         idex_bubble = hz;
      end
   end

   assign state = state_q;

   // Load-use hazard against the insn in ID
   assign rs_hit = (ex_rd == id_rs) && !(R0_ZERO && (id_rs == '0));
   assign rt_hit = id_uses_rt && (ex_rd == id_rt) && !(R0_ZERO && (id_rt == '0));
   assign hz     = ex_memread && ex_regwrite && (rs_hit || rt_hit);

   // Same-cycle WB write seen by the ID register read
   assign wb_id_rs_hit = wb_regwrite && (wb_rd == id_rs) && !(R0_ZERO && (id_rs == '0));
   assign wb_id_rt_hit = wb_regwrite && (wb_rd == id_rt) && !(R0_ZERO && (id_rt == '0));
   assign id_rd1       = wb_id_rs_hit ? wb_fwd_data : id_rd1_raw;
   assign id_rd2       = wb_id_rt_hit ? wb_fwd_data : id_rd2_raw;

   fwd_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .R0_ZERO(R0_ZERO)) u_fwd_a (
      .src_i          (ex_rs),
      .mem_rd_i       (mem_rd),
      .mem_regwrite_i (mem_regwrite),
      .mem_memread_i  (mem_memread),
      .mem_data_i     (mem_fwd_data),
      .wb_rd_i        (wb_rd),
      .wb_regwrite_i  (wb_regwrite),
      .wb_data_i      (wb_fwd_data),
      .raw_i          (ex_opa_raw),
      .sel_o          (fwd_a_sel),
      .data_o         (ex_opa)
   );

   fwd_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .R0_ZERO(R0_ZERO)) u_fwd_b (
      .src_i          (ex_rt),
      .mem_rd_i       (mem_rd),
      .mem_regwrite_i (mem_regwrite),
      .mem_memread_i  (mem_memread),
      .mem_data_i     (mem_fwd_data),
      .wb_rd_i        (wb_rd),
      .wb_regwrite_i  (wb_regwrite),
      .wb_data_i      (wb_fwd_data),
      .raw_i          (ex_opb_raw),
      .sel_o          (fwd_b_sel),
      .data_o         (ex_opb)
   );

   // Valid bits and retire count move only on advance; a hazard holds IFID and empties IDEX
   always_comb begin
      v_ifid_d     = v_ifid_q;
      v_idex_d     = v_idex_q;
      v_exmem_d    = v_exmem_q;
      v_memwb_d    = v_memwb_q;
      retire_cnt_d = retire_cnt_q;
      if (adv) begin
         v_ifid_d  = hz ? v_ifid_q : 1'b1;
         v_idex_d  = hz ? 1'b0 : v_ifid_q;
         v_exmem_d = v_idex_q;
         v_memwb_d = v_exmem_q;
         if (v_memwb_q) retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v_ifid_q     <= 1'b0;
         v_idex_q     <= 1'b0;
         v_exmem_q    <= 1'b0;
         v_memwb_q    <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         v_ifid_q     <= v_ifid_d;
         v_idex_q     <= v_idex_d;
         v_exmem_q    <= v_exmem_d;
         v_memwb_q    <= v_memwb_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      halt_cnt_d  = halt_cnt_q;
      if (adv && hz)            stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (state_q == ST_HALT)   halt_cnt_d  = halt_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         halt_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         halt_cnt_q  <= halt_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign halt_cnt  = halt_cnt_q;
`else
   assign stall_cnt = '0;
   assign halt_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl: FSM/step, retire timing, load-use stall,
// forwarding priority, R0 masking, ID bypass and asynchronous reset.
module tb_pipe_hazard_ctl;

`ifdef PIPE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        CLK, RST, pause, step;
   logic [2:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic        id_uses_rt, ex_memread, ex_regwrite;
   logic        mem_regwrite, mem_memread, wb_regwrite;
   logic [15:0] id_rd1_raw, id_rd2_raw, mem_fwd_data, wb_fwd_data;
   logic [15:0] ex_opa_raw, ex_opb_raw;
   logic        adv, pc_we, ifid_we, idex_bubble;
   logic [15:0] id_rd1, id_rd2, ex_opa, ex_opb;
   logic [1:0]  fwd_a_sel, fwd_b_sel, state;
   logic [31:0] retire_cnt, stall_cnt, halt_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_hazard_ctl dut (
      .CLK(CLK), .RST(RST), .pause(pause), .step(step),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_rd1_raw(id_rd1_raw), .id_rd2_raw(id_rd2_raw),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .mem_fwd_data(mem_fwd_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .wb_fwd_data(wb_fwd_data), .ex_opa_raw(ex_opa_raw), .ex_opb_raw(ex_opb_raw),
      .adv(adv), .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .ex_opa(ex_opa), .ex_opb(ex_opb),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .state(state),
      .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .halt_cnt(halt_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
      n_checks++; if (adv !== 1'b0) begin n_fail++; $display("FAIL reset_adv got=%b exp=0", adv); end
      n_checks++; if (pc_we !== 1'b0 || ifid_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b%b exp=00", pc_we, ifid_we); end
      n_checks++; if (idex_bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got=%b exp=0", idex_bubble); end
      n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_retire got=%0d exp=0", retire_cnt); end
      n_checks++; if (stall_cnt !== 32'd0 || halt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cnt, halt_cnt); end
   endtask

   task automatic test_run_retire();
      pause = 1'b0;
      RST   = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL run_state got=%0d exp=1", state); end
      n_checks++; if (adv !== 1'b1 || pc_we !== 1'b1 || ifid_we !== 1'b1) begin n_fail++; $display("FAIL run_adv got=%b%b%b exp=111", adv, pc_we, ifid_we); end
      // edge 1 sets v_ifid; retire is counted on the 5th advance edge
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL retire_early got=%0d exp=0", retire_cnt); end
      @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL retire_first got=%0d exp=1", retire_cnt); end
      @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (retire_cnt !== 32'd2) begin n_fail++; $display("FAIL retire_second got=%0d exp=2", retire_cnt); end
   endtask

   task automatic test_hazard();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd2; id_rs = 3'd2;
      #1;
      n_checks++; if (pc_we !== 1'b0 || ifid_we !== 1'b0) begin n_fail++; $display("FAIL hz_we got=%b%b exp=00", pc_we, ifid_we); end
      n_checks++; if (idex_bubble !== 1'b1) begin n_fail++; $display("FAIL hz_bubble got=%b exp=1", idex_bubble); end
      @(posedge CLK);
      @(negedge CLK);
      ex_memread = 1'b0;
      #1;
      n_checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin n_fail++; $display("FAIL hz_release got=%b%b exp=10", pc_we, idex_bubble); end
      n_checks++; if (stall_cnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL hz_stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? 1 : 0); end
      n_checks++; if (retire_cnt !== 32'd3) begin n_fail++; $display("FAIL hz_retire got=%0d exp=3", retire_cnt); end
      // rt match only counts when the ID insn reads rt
      ex_memread = 1'b1; id_rs = 3'd5; id_rt = 3'd2; id_uses_rt = 1'b0;
      #1;
      n_checks++; if (idex_bubble !== 1'b0 || pc_we !== 1'b1) begin n_fail++; $display("FAIL hz_rt_unused got=%b%b exp=01", idex_bubble, pc_we); end
      id_uses_rt = 1'b1;
      #1;
      n_checks++; if (idex_bubble !== 1'b1 || pc_we !== 1'b0) begin n_fail++; $display("FAIL hz_rt_used got=%b%b exp=10", idex_bubble, pc_we); end
      ex_rd = 3'd0; id_rs = 3'd0; id_rt = 3'd0;
      #1;
      n_checks++; if (idex_bubble !== 1'b0) begin n_fail++; $display("FAIL hz_r0 got=%b exp=0", idex_bubble); end
      ex_memread = 1'b0; id_uses_rt = 1'b0;
      pause = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      ex_memread = 1'b1; ex_rd = 3'd2; id_rs = 3'd2;
      #1;
      n_checks++; if (adv !== 1'b0 || idex_bubble !== 1'b0 || pc_we !== 1'b0) begin n_fail++; $display("FAIL hz_halt got=%b%b%b exp=000", adv, idex_bubble, pc_we); end
      n_checks++; if (retire_cnt !== 32'd4) begin n_fail++; $display("FAIL halt_retire got=%0d exp=4", retire_cnt); end
      ex_memread = 1'b0;
   endtask

   task automatic test_step();
      int adv_total = 0;
      logic [31:0] exp_ret [3];
      // the bubble from the hazard reaches WB on the second step
      exp_ret[0] = 32'd5; exp_ret[1] = 32'd5; exp_ret[2] = 32'd6;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         step = 1'b1;
         for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            step = 1'b0;
            if (adv === 1'b1) adv_total++;
            if (c == 0) begin
               n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL step_state k=%0d got=%0d exp=2", k, state); end
            end
         end
         n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL step_back_halt k=%0d got=%0d exp=0", k, state); end
         n_checks++; if (retire_cnt !== exp_ret[k]) begin n_fail++; $display("FAIL step_retire k=%0d got=%0d exp=%0d", k, retire_cnt, exp_ret[k]); end
      end
      n_checks++; if (adv_total != 3) begin n_fail++; $display("FAIL step_adv_total got=%0d exp=3", adv_total); end
   endtask

   task automatic test_forward();
      mem_rd = 3'd3; wb_rd = 3'd3; ex_rs = 3'd3; ex_rt = 3'd3;
      mem_regwrite = 1'b1; mem_memread = 1'b0; wb_regwrite = 1'b1;
      mem_fwd_data = 16'h00AA; wb_fwd_data = 16'h0055;
      ex_opa_raw = 16'h1234; ex_opb_raw = 16'h5678;
      #1;
      n_checks++; if (fwd_a_sel !== 2'd2 || ex_opa !== 16'h00AA) begin n_fail++; $display("FAIL fwd_mem_a got=%0d/%h exp=2/00aa", fwd_a_sel, ex_opa); end
      n_checks++; if (fwd_b_sel !== 2'd2 || ex_opb !== 16'h00AA) begin n_fail++; $display("FAIL fwd_mem_b got=%0d/%h exp=2/00aa", fwd_b_sel, ex_opb); end
      mem_regwrite = 1'b0;
      #1;
      n_checks++; if (fwd_a_sel !== 2'd1 || ex_opa !== 16'h0055) begin n_fail++; $display("FAIL fwd_wb_a got=%0d/%h exp=1/0055", fwd_a_sel, ex_opa); end
      mem_regwrite = 1'b1; mem_memread = 1'b1;
      #1;
      n_checks++; if (fwd_b_sel !== 2'd1 || ex_opb !== 16'h0055) begin n_fail++; $display("FAIL fwd_load_skip got=%0d/%h exp=1/0055", fwd_b_sel, ex_opb); end
      mem_memread = 1'b0; ex_rs = 3'd4;
      #1;
      n_checks++; if (fwd_a_sel !== 2'd0 || ex_opa !== 16'h1234) begin n_fail++; $display("FAIL fwd_raw got=%0d/%h exp=0/1234", fwd_a_sel, ex_opa); end
      id_rs = 3'd3; id_rt = 3'd3; id_rd1_raw = 16'h1111; id_rd2_raw = 16'h2222;
      #1;
      n_checks++; if (id_rd1 !== 16'h0055 || id_rd2 !== 16'h0055) begin n_fail++; $display("FAIL id_bypass got=%h/%h exp=0055/0055", id_rd1, id_rd2); end
      id_rt = 3'd6;
      #1;
      n_checks++; if (id_rd2 !== 16'h2222) begin n_fail++; $display("FAIL id_no_bypass got=%h exp=2222", id_rd2); end
   endtask

   task automatic test_r0();
      mem_regwrite = 1'b0; wb_regwrite = 1'b1; wb_rd = 3'd0; ex_rs = 3'd0; id_rs = 3'd0;
      #1;
      n_checks++; if (fwd_a_sel !== 2'd0 || ex_opa !== 16'h1234) begin n_fail++; $display("FAIL r0_fwd got=%0d/%h exp=0/1234", fwd_a_sel, ex_opa); end
      n_checks++; if (id_rd1 !== 16'h1111) begin n_fail++; $display("FAIL r0_bypass got=%h exp=1111", id_rd1); end
      wb_regwrite = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      step = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      step = 1'b0;
      n_checks++; if (state !== 2'd2 || adv !== 1'b1) begin n_fail++; $display("FAIL arst_pre got=%0d/%b exp=2/1", state, adv); end
      #2 RST = 1'b1;
      #1;
      n_checks++; if (state !== 2'd0 || adv !== 1'b0 || pc_we !== 1'b0) begin n_fail++; $display("FAIL arst_fsm got=%0d/%b/%b exp=0/0/0", state, adv, pc_we); end
      n_checks++; if (retire_cnt !== 32'd0 || stall_cnt !== 32'd0 || halt_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_cnt got=%0d/%0d/%0d exp=0/0/0", retire_cnt, stall_cnt, halt_cnt); end
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      n_checks++; if (state !== 2'd0 || adv !== 1'b0) begin n_fail++; $display("FAIL arst_after got=%0d/%b exp=0/0", state, adv); end
   endtask

   initial begin
      RST = 1'b1; pause = 1'b1; step = 1'b0;
      id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_rd1_raw = '0; id_rd2_raw = '0;
      ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_memread = 1'b0; ex_regwrite = 1'b0;
      mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0; mem_fwd_data = '0;
      wb_rd = '0; wb_regwrite = 1'b0; wb_fwd_data = '0; ex_opa_raw = '0; ex_opb_raw = '0;
      test_reset();
      test_run_retire();
      test_hazard();
      test_step();
      test_forward();
      test_r0();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
